bp_cfg_broadcast: RTL
=====================

# bp_cfg_broadcast

Runtime configuration broadcaster sitting between the host config bus and the core array. It holds a host-programmed preset-configuration index, a core target mask and freeze state, and on a commit walks every core slot in order, delivering the selected preset index over a shared valid/ready link. It then optionally releases each core's freeze. This generalises the compile-time preset table to a runtime-selected, per-core-masked, handshaked delivery with error reporting.

## Interface
Parameters:
- num_core_p, 16, number of core slots (≥2)
- num_cfgs_p, 10, number of defined preset indices; valid selections are 1..num_cfgs_p-1 (0 = invalid config)
- lg_max_cfgs_p, 7, width of a preset index
- data_width_p, 64, host write data width
- addr_width_p, 4, host write address width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- w_v_i  in  1  host write valid
- w_ready_o  out  1  host write ready; low while busy_o
- w_addr_i  in  addr_width_p  register address
- w_data_i  in  data_width_p  write data
- cfg_v_o  out  1  config packet valid
- cfg_ready_i  in  1  config packet accepted
- cfg_core_o  out  clog2(num_core_p)  destination core index
- cfg_sel_o  out  lg_max_cfgs_p  preset index being delivered
- core_freeze_o  out  num_core_p  per-core freeze
- busy_o  out  1  broadcast in progress
- done_o  out  1  one-cycle pulse at broadcast completion
- err_o  out  1  sticky error

## Operation
- Registers (write on w_v_i & w_ready_o):
  - 0x0 sel ← data[lg_max_cfgs_p-1:0]
  - 0x1 mask ← data[num_core_p-1:0]
  - 0x2 commit; data[0] = unfreeze-on-delivery
  - 0x3 freeze_all; data[0]=1 sets all core_freeze_o, 0 has no effect
  - 0x4 err clear
  - Other addresses: accepted, ignored, set err.
- FSM states: IDLE, SEND, DONE.
  - IDLE → SEND on a commit write with 1 ≤ sel < num_cfgs_p and mask ≠ 0. Snapshot sel, mask and the unfreeze flag; set ptr=0.
  - Commit with invalid sel or mask=0: set err, stay IDLE, no packets sent.
  - SEND, mask_snap[ptr]=0: skip; ptr++ next cycle, cfg_v_o low.
  - SEND, mask_snap[ptr]=1: drive cfg_v_o=1, cfg_core_o=ptr, cfg_sel_o=sel_snap. Hold them stable until cfg_ready_i. On handshake, clear core_freeze_o[ptr] if the unfreeze flag is set, then ptr++.
  - ptr advancing past num_core_p-1 → DONE. DONE asserts done_o for one cycle → IDLE.
- Host writes to sel/mask during SEND are impossible (w_ready_o=0); the snapshot guarantees consistency.
- Unmasked cores' freeze bits never change during a broadcast.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, sel=0, mask=all ones, err=0, core_freeze_o=all ones. Outputs: w_ready_o=1, cfg_v_o=0, cfg_core_o=0, cfg_sel_o=0, busy_o=0, done_o=0.
- busy_o=1 in SEND and DONE. w_ready_o = !busy_o, combinational from state.
- The commit accepted at edge t puts the FSM in SEND from cycle t+1. With cfg_ready_i held high, the broadcast takes exactly num_core_p SEND cycles (masked or skipped, one each), then DONE. done_o is high in cycle t+1+num_core_p.
- Each stall cycle (cfg_v_o & !cfg_ready_i) adds one cycle. cfg_v_o never deasserts without a handshake.
- Freeze bit clears at the handshake edge and is visible the next cycle.
- freeze_all and a commit cannot coincide (single write port). A freeze_all write in IDLE takes effect the next cycle.
- Reset mid-broadcast: abort immediately and return to reset values. Remaining cores are not delivered.
- err sets on the cycle after the offending write. It stays set until a 0x4 write or reset. An err-clear write and an offending write cannot coincide.

## Test plan
- Reset → core_freeze_o=0xFFFF, w_ready_o=1, cfg_v_o=0, err_o=0.
- sel=2, mask=0xFFFF, commit data=1, ready high → 16 packets, cores 0..15, cfg_sel_o=2. done_o exactly 17 cycles after the commit edge. core_freeze_o=0 afterward.
- sel=5, mask=0x0005, commit data=0 → packets only to cores 0 and 2. done_o at commit+17. core_freeze_o unchanged at 0xFFFF.
- Same as above with cfg_ready_i low for 3 cycles on core 2 → cfg_v_o and payload held stable. done_o at commit+20.
- sel=0 or sel=10, commit → err_o=1, busy_o stays 0, no cfg_v_o. A 0x4 write clears err_o. A write to 0x9 sets err_o.
- reset_n_i low during core 7 delivery → immediately IDLE, freeze all ones. No further packets. A new commit works normally.

Source files
------------

// File: rtl/bp_cfg_broadcast.sv
// -----------------------------------------------------------------------------
// bp_cfg_broadcast
//
// Runtime configuration broadcaster between the host config bus and the core
// array. The host programs a preset index (sel) and a core target mask, then
// issues a commit. The block walks every core slot in ascending order. For
// each masked core it delivers the preset index over a shared valid/ready
// link. Each freeze bit can optionally be released at delivery time.
//
// Ports
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   w_v_i / w_ready_o  host register write handshake (ready low while busy)
//   w_addr_i, w_data_i host register address / data
//   cfg_v_o / cfg_ready_i  config packet handshake
//   cfg_core_o, cfg_sel_o  packet payload: destination core, preset index
//   core_freeze_o      per-core freeze (reset: all frozen)
//   busy_o             broadcast in progress (SEND or DONE)
//   done_o             one-cycle completion pulse
//   err_o              sticky error, cleared by a write to 0x4
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once cfg_v_o rises, it and its payload stay stable until that
// transfer occurs.
//
// Register map: 0x0 sel, 0x1 mask, 0x2 commit (data[0] = unfreeze on
// delivery), 0x3 freeze_all (data[0] = 1 freezes all cores), 0x4 error clear.
// Any other address is accepted but sets err.
// -----------------------------------------------------------------------------
module bp_cfg_broadcast #(
   parameter int num_core_p    = 16,
   parameter int num_cfgs_p    = 10,
   parameter int lg_max_cfgs_p = 7,
   parameter int data_width_p  = 64,
   parameter int addr_width_p  = 4,
   localparam int core_w_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     w_v_i,
   output logic                     w_ready_o,
   input  logic [addr_width_p-1:0]  w_addr_i,
   input  logic [data_width_p-1:0]  w_data_i,
   output logic                     cfg_v_o,
   input  logic                     cfg_ready_i,
   output logic [core_w_lp-1:0]     cfg_core_o,
   output logic [lg_max_cfgs_p-1:0] cfg_sel_o,
   output logic [num_core_p-1:0]    core_freeze_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [addr_width_p-1:0] addr_sel_lp    = addr_width_p'(0);
   localparam logic [addr_width_p-1:0] addr_mask_lp   = addr_width_p'(1);
   localparam logic [addr_width_p-1:0] addr_commit_lp = addr_width_p'(2);
   localparam logic [addr_width_p-1:0] addr_freeze_lp = addr_width_p'(3);
   localparam logic [addr_width_p-1:0] addr_errclr_lp = addr_width_p'(4);
   localparam logic [core_w_lp-1:0]    last_core_lp   = core_w_lp'(num_core_p - 1);

   state_e                   state_q, state_d;
   logic [lg_max_cfgs_p-1:0] sel_q, sel_d;
   logic [lg_max_cfgs_p-1:0] sel_snap_q, sel_snap_d;
   logic [num_core_p-1:0]    mask_q, mask_d;
   logic [num_core_p-1:0]    mask_snap_q, mask_snap_d;
   logic [num_core_p-1:0]    freeze_q, freeze_d;
   logic                     unfreeze_q, unfreeze_d;
   logic [core_w_lp-1:0]     ptr_q, ptr_d;
   logic                     err_q, err_d;

   logic wr_fire;
   logic sel_valid;
   logic cur_masked;
   logic advance;

   assign w_ready_o  = (state_q == ST_IDLE);
   assign wr_fire    = w_v_i & w_ready_o;
   // Index 0 is the reserved "invalid config"; indices at or above
   // num_cfgs_p are undefined presets.
   assign sel_valid  = (sel_q != '0) && (int'(sel_q) < num_cfgs_p);
   assign cur_masked = mask_snap_q[ptr_q];
   // Unmasked slots take one cycle each; masked slots wait for the handshake.
   assign advance    = !cur_masked || cfg_ready_i;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      sel_snap_d  = sel_snap_q;
      mask_d      = mask_q;
      mask_snap_d = mask_snap_q;
      freeze_d    = freeze_q;
      unfreeze_d  = unfreeze_q;
      ptr_d       = ptr_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (wr_fire) begin
               case (w_addr_i)
                  addr_sel_lp:  sel_d  = w_data_i[lg_max_cfgs_p-1:0];
                  addr_mask_lp: mask_d = w_data_i[num_core_p-1:0];
                  addr_commit_lp: begin
                     if (sel_valid && (mask_q != '0)) begin
                        state_d     = ST_SEND;
                        sel_snap_d  = sel_q;
                        mask_snap_d = mask_q;
                        unfreeze_d  = w_data_i[0];
                        ptr_d       = '0;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  addr_freeze_lp: begin
                     if (w_data_i[0]) freeze_d = '1;
                  end
                  addr_errclr_lp: err_d = 1'b0;
                  default:        err_d = 1'b1;
               endcase
            end
         end

         ST_SEND: begin
            if (cur_masked && cfg_ready_i && unfreeze_q) begin
               freeze_d[ptr_q] = 1'b0;
            end
            if (advance) begin
               if (ptr_q == last_core_lp) begin
                  state_d = ST_DONE;
               end else begin
                  ptr_d = ptr_q + core_w_lp'(1);
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         sel_snap_q  <= '0;
         mask_q      <= '1;
         mask_snap_q <= '0;
         freeze_q    <= '1;
         unfreeze_q  <= 1'b0;
         ptr_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         sel_snap_q  <= sel_snap_d;
         mask_q      <= mask_d;
         mask_snap_q <= mask_snap_d;
         freeze_q    <= freeze_d;
         unfreeze_q  <= unfreeze_d;
         ptr_q       <= ptr_d;
         err_q       <= err_d;
      end
   end

   // The payload reads as zero whenever no packet is offered.
   assign cfg_v_o       = (state_q == ST_SEND) && cur_masked;
   assign cfg_core_o    = cfg_v_o ? ptr_q : '0;
   assign cfg_sel_o     = cfg_v_o ? sel_snap_q : '0;
   assign core_freeze_o = freeze_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = (state_q == ST_DONE);
   assign err_o         = err_q;

endmodule
